// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control FSM; strobes are combinational from state and handshakes.
// Wait states stall on imem/dmem/alu handshakes; defining SEQ_TIMEOUT_EN adds a watchdog that halts with a sticky fault.
module instr_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             alu_done,
   input  logic             hlt,
   input  logic             bra,
   input  logic             RD,
   input  logic             WR,
   input  logic             alu_en,
   input  logic             mov_en,
   input  logic             psh,
   input  logic             pop,
   output logic             imem_req,
   output logic             ir_load,
   output logic             cu_en,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             dmem_req,
   output logic             alu_start,
   output logic             reg_we,
   output logic             flags_we,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_ALU    = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   logic             timeout;
   logic             unused_cu;

   // psh/pop retire exactly like a NOP here; the stack work happens elsewhere.
   assign unused_cu = psh ^ pop;

`ifdef SEQ_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fault_q, fault_d;
   logic              waiting;

   assign waiting = (state_q == S_FETCH && !imem_ready) ||
                    (state_q == S_MEM   && !dmem_ready) ||
                    (state_q == S_ALU   && !alu_done);
   assign timeout = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
   // Any cycle that is not a stalled wait cycle (including every state entry) clears the count.
   assign wait_d  = (waiting && !timeout) ? wait_q + WAIT_W'(1) : '0;
   assign fault_d = fault_q | timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH:  if (imem_ready) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (hlt)            state_d = S_HALT;
            else if (bra)       state_d = S_FETCH;
            else if (RD || WR)  state_d = S_MEM;
            else if (alu_en)    state_d = S_ALU;
            else                state_d = S_FETCH;
         end
         S_MEM:    if (dmem_ready) state_d = S_FETCH;
         S_ALU:    if (alu_done) state_d = S_FETCH;
         S_HALT:   if (start) state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
      if (timeout) state_d = S_HALT;
   end

   always_comb begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      cu_en     = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      dmem_req  = 1'b0;
      alu_start = 1'b0;
      reg_we    = 1'b0;
      flags_we  = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
         end
         S_DECODE: cu_en = 1'b1;
         S_EXEC: begin
            if (hlt) begin
               retire = 1'b1;
            end else if (bra) begin
               pc_load = 1'b1;
               retire  = 1'b1;
            end else if (RD || WR) begin
               retire = 1'b0;
            end else if (alu_en) begin
               alu_start = 1'b1;
            end else begin
               reg_we = mov_en;
               pc_inc = 1'b1;
               retire = 1'b1;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               reg_we = RD;
               pc_inc = 1'b1;
               retire = 1'b1;
            end
         end
         S_ALU: begin
            if (alu_done) begin
               reg_we   = 1'b1;
               flags_we = 1'b1;
               pc_inc   = 1'b1;
               retire   = 1'b1;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            pc_inc = start;
         end
         default: retire = 1'b0;
      endcase
   end

   assign retired_d = retired_q + CNT_W'(retire);
   assign retired   = retired_q;
   assign state     = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: driver issues instructions, monitor checks retirements.
`timescale 1ns/1ps
module tb_instr_sequencer;
   localparam int CW = 4;
   localparam int TO = 4;
`ifdef SEQ_TIMEOUT_EN
   localparam int MAXW = TO - 1;
`else
   localparam int MAXW = 6;
`endif
   localparam int K_NOP = 0, K_HLT = 1, K_BRT = 2, K_BRN = 3, K_LDR = 4,
                  K_STR = 5, K_ALU = 6, K_MOV = 7, K_RES = 8;

   typedef struct {
      int             kind;
      logic           inc, ld, we, fwe;
      int             lat, starts, dcyc;
      logic [CW-1:0]  ret;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic imem_ready = 1'b0, dmem_ready = 1'b0, alu_done = 1'b0;
   logic hlt = 1'b0, bra = 1'b0, RD = 1'b0, WR = 1'b0, alu_en = 1'b0, mov_en = 1'b0, psh = 1'b0, pop = 1'b0;
   logic imem_req, ir_load, cu_en, pc_inc, pc_load, dmem_req, alu_start, reg_we, flags_we, halted, fault;
   logic [2:0]    state;
   logic [CW-1:0] retired;

   int   checks = 0, errors = 0;
   exp_t sbq[$];
   logic mon_en = 1'b0, noise_en = 1'b0;
   int   n_ret = 0;
   int   cyc = 0, fstart = 0, cu_cnt = 0, as_cnt = 0, dq_cnt = 0, spur = 0;
   logic prev_req = 1'b0, prev_halt = 1'b0, ret_pend = 1'b0;
   logic [CW-1:0] ret_exp = '0;

   always #5 clk = ~clk;

   instr_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_done(alu_done),
      .hlt(hlt), .bra(bra), .RD(RD), .WR(WR), .alu_en(alu_en), .mov_en(mov_en), .psh(psh), .pop(pop),
      .imem_req(imem_req), .ir_load(ir_load), .cu_en(cu_en), .pc_inc(pc_inc), .pc_load(pc_load),
      .dmem_req(dmem_req), .alu_start(alu_start), .reg_we(reg_we), .flags_we(flags_we),
      .halted(halted), .fault(fault), .state(state), .retired(retired)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired (t=%0t)", name, $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   function automatic logic [10:0] outs();
      return {imem_req, ir_load, cu_en, pc_inc, pc_load, dmem_req, alu_start, reg_we, flags_we, halted, fault};
   endfunction

   task automatic step();
      @(negedge clk);
      start      = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      alu_done   = 1'b0;
   endtask

   // Reference behaviour of one instruction: Control_Unit pattern and expected retirement.
   task automatic mk(input int k, input int iw, input int dw, input int aw,
                     output logic [7:0] cu, output exp_t e);
      logic [31:0] r;
      r = $urandom;
      e.kind = k; e.inc = 1'b1; e.ld = 1'b0; e.we = 1'b0; e.fwe = 1'b0;
      e.lat = iw + 3; e.starts = 0; e.dcyc = 0;
      case (k)
         K_HLT: begin cu = {1'b1, r[6:0]}; e.inc = 1'b0; end
         K_BRT: begin cu = {2'b01, r[5:0]}; e.inc = 1'b0; e.ld = 1'b1; end
         K_LDR: begin cu = {4'b0010, r[3:0]}; e.we = 1'b1; e.lat += dw + 1; e.dcyc = dw + 1; end
         K_STR: begin cu = {4'b0001, r[3:0]}; e.lat += dw + 1; e.dcyc = dw + 1; end
         K_ALU: begin cu = {5'b00001, r[2:0]}; e.we = 1'b1; e.fwe = 1'b1; e.lat += aw + 1; e.starts = 1; end
         K_MOV: begin cu = {6'b000001, r[1:0]}; e.we = 1'b1; end
         default: cu = {6'b000000, r[1:0]};
      endcase
      n_ret++;
      e.ret = CW'(n_ret);
   endtask

   task automatic run_instr(input int k, input int iw, input int dw, input int aw, input int gap);
      logic [7:0] cu;
      exp_t e, r;
      int cnt;
      mk(k, iw, dw, aw, cu, e);
      sbq.push_back(e);
      cnt = 0;
      for (int g = 0; g <= 200; g++) begin
         if (g == 200) bound_fail("fetch");
         step();
         if (imem_req) begin
            if (cnt == iw) begin
               imem_ready = 1'b1;
               {hlt, bra, RD, WR, alu_en, mov_en, psh, pop} = cu;
               break;
            end
            cnt++;
         end
      end
      if (k == K_LDR || k == K_STR) begin
         cnt = 0;
         for (int g = 0; g <= 200; g++) begin
            if (g == 200) bound_fail("dmem");
            step();
            if (dmem_req) begin
               if (cnt == dw) begin dmem_ready = 1'b1; break; end
               cnt++;
            end
         end
      end else if (k == K_ALU) begin
         for (int g = 0; g <= 20; g++) begin
            if (g == 20) bound_fail("alu_start");
            step();
            if (alu_start) break;
         end
         for (int c = 0; c <= aw; c++) begin
            step();
            if (c == aw) alu_done = 1'b1;
         end
      end else if (k == K_HLT) begin
         for (int g = 0; g <= 20; g++) begin
            if (g == 20) bound_fail("halt");
            step();
            if (halted) break;
         end
         noise_en = 1'b0;
         start = 1'b0;
         for (int c = 0; c < gap; c++) step();
         start = 1'b1;
         r.kind = K_RES; r.inc = 1'b1; r.ld = 1'b0; r.we = 1'b0; r.fwe = 1'b0;
         r.lat = 0; r.starts = 0; r.dcyc = 0; r.ret = e.ret;
         sbq.push_back(r);
         noise_en = 1'b1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic evt_done, evt_halt, evt_res;
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (!mon_en) begin
            prev_req = imem_req; prev_halt = halted; ret_pend = 1'b0;
            continue;
         end
         if (ret_pend) begin chk("retired", retired, ret_exp); ret_pend = 1'b0; end
         if (imem_req && !prev_req) begin fstart = cyc; cu_cnt = 0; as_cnt = 0; dq_cnt = 0; end
         if (imem_req) chk("ir_load", ir_load, imem_ready);
         if (cu_en) cu_cnt++;
         if (alu_start) as_cnt++;
         if (dmem_req) dq_cnt++;
         evt_done = (pc_inc || pc_load) && !halted;
         evt_halt = halted && !prev_halt;
         evt_res  = halted && start;
         if (evt_done || evt_halt) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_retire actual=event expected=none (t=%0t)", $time);
            end else begin
               e = sbq.pop_front();
               chk("is_hlt", evt_halt, e.kind == K_HLT);
               if (evt_done) begin
                  chk("pc_inc", pc_inc, e.inc);
                  chk("pc_load", pc_load, e.ld);
                  chk("reg_we", reg_we, e.we);
                  chk("flags_we", flags_we, e.fwe);
                  ret_pend = 1'b1;
                  ret_exp  = e.ret;
                  chk("latency", cyc - fstart + 1, e.lat);
               end else begin
                  chk("retired_hlt", retired, e.ret);
                  chk("latency", cyc - fstart, e.lat);
               end
               chk("cu_en_count", cu_cnt, 1);
               chk("alu_start_count", as_cnt, e.starts);
               chk("dmem_req_cycles", dq_cnt, e.dcyc);
            end
         end
         if (evt_res) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resume actual=event expected=none (t=%0t)", $time);
            end else begin
               e = sbq.pop_front();
               chk("resume_kind", e.kind, K_RES);
               chk("resume_pc_inc", pc_inc, 1'b1);
               chk("resume_strobes", {pc_load, reg_we, flags_we}, 3'b000);
            end
         end
         if (!evt_done && !evt_res && (reg_we || flags_we || pc_load || pc_inc)) spur++;
         prev_req = imem_req;
         prev_halt = halted;
      end
   end

   initial begin : driver
      int k, aw;
      #1;
      chk("reset_outputs", outs(), 11'd0);
      chk("reset_state", state, 3'd0);
      chk("reset_retired", retired, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Abort mid-FETCH with an asynchronous reset.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("pre_reset_fetch", {imem_req, state}, {1'b1, 3'd1});
      rst = 1'b1;
      #1;
      chk("async_reset_state", state, 3'd0);
      chk("async_reset_outputs", outs(), 11'd0);
      chk("async_reset_retired", retired, 0);
      @(negedge clk); rst = 1'b0;

      mon_en = 1'b1;
      step();
      start = 1'b1;
      noise_en = 1'b1;
      aw = (5 < MAXW) ? 5 : MAXW;
      run_instr(K_NOP, 0, 0, 0, 0);
      run_instr(K_HLT, 0, 0, 0, 2);
      run_instr(K_ALU, 0, 0, aw, 0);
      run_instr(K_LDR, 0, 2, 0, 0);
      run_instr(K_STR, 1, 0, 0, 0);
      run_instr(K_BRT, 0, 0, 0, 0);
      run_instr(K_BRN, 0, 0, 0, 0);
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 7);
         run_instr(k, $urandom_range(0, MAXW), $urandom_range(0, MAXW),
                   $urandom_range(0, MAXW), $urandom_range(0, 3));
      end
      noise_en = 1'b0;
      for (int g = 0; g < 50 && sbq.size() != 0; g++) step();
      repeat (2) step();
      chk("scoreboard_drain", sbq.size(), 0);
      chk("spurious_strobes", spur, 0);
      chk("fault_clear", fault, 1'b0);
      mon_en = 1'b0;

`ifdef SEQ_TIMEOUT_EN
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      step();
      start = 1'b1;
      for (int c = 1; c <= TO; c++) step();
      chk("timeout_not_early", halted, 1'b0);
      step();
      chk("timeout_halt_fault", {halted, fault}, 2'b11);
      start = 1'b1;
      #1;
      chk("timeout_resume_pc_inc", pc_inc, 1'b1);
      step();
      chk("timeout_resume_state", state, 3'd1);
      chk("fault_sticky", fault, 1'b1);
      rst = 1'b1;
      #1;
      chk("fault_cleared_by_rst", fault, 1'b0);
      @(negedge clk); rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
